// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract controller built around one
// 1-bit fulladder cell. Operands are shifted LSB-first through the cell,
// one bit per clock, and the result is returned with carry and overflow.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (accepted only in IDLE)
//   a, b                 WIDTH-bit operands
//   cin                  carry-in for add (ignored when sub=1)
//   sub                  0: a+b+cin, 1: a-b
//   out_valid/out_ready  result handshake (result held until taken)
//   sum, cout, ovf       result, final carry (sub: 1 = no borrow), signed ovf
//   busy                 high while an operation is in RUN or DONE
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   in_ready_d, out_valid_d, busy_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;   // bits already produced, newest at the top
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  assign accept   = in_valid && in_ready;
  assign last_bit = (state_q == S_RUN) && (cnt == LAST);
  assign res_nxt  = {fa_s, res_sh};

  // The single time-shared adder cell
  fulladder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // State register with registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state so outputs come straight from flops
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      S_IDLE:  in_ready_d  = 1'b1;
      S_RUN:   busy_d      = 1'b1;
      S_DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: in_ready_d  = 1'b1;
    endcase
  end

  // Serial datapath: operand capture, bit shifting and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        a_sh  <= a;
        // Subtract as a + ~b + 1
        b_sh  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        cnt   <= '0;
      end
    end else if (state_q == S_RUN) begin
      res_sh <= res_nxt[WIDTH-1:1];
      carry  <= fa_co;
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      if (last_bit) begin
        sum  <= res_nxt;
        cout <= fa_co;
        // carry into the MSB differs from carry out of it
        ovf  <= carry ^ fa_co;
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule

// fulladder: 1-bit full adder cell (a, b, cin -> s, cout)
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): stimulus pushes the
// hand-computed result into a queue, a monitor pops on each output handshake.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t        q[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted result against the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_result: got sum %0h with empty scoreboard", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
        check("ovf", 32'(ovf), 32'(e.o));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair; returns #1 after the accept edge
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input exp_t e);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
    q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, then let the handshake edge pass
  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
    step();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    rst_n = 1'b1;
    step();

    // 0x5A+0x3C with exact latency: out_valid after the 8th edge
    issue(8'h5A, 8'h3C, 1'b0, 1'b0, '{s: 8'h96, c: 1'b0, o: 1'b1});
    check("run_busy", 32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) check("latency_early", 32'(out_valid), 32'd0);
      if (i == 8) check("latency_edge8", 32'(out_valid), 32'd1);
    end
    step();
    check("idle_after_take", 32'(in_ready), 32'd1);

    issue(8'hFF, 8'h01, 1'b0, 1'b0, '{s: 8'h00, c: 1'b1, o: 1'b0});
    wait_done();
    issue(8'h00, 8'h00, 1'b1, 1'b0, '{s: 8'h01, c: 1'b0, o: 1'b0});
    wait_done();
    issue(8'h10, 8'h20, 1'b1, 1'b1, '{s: 8'hF0, c: 1'b0, o: 1'b0});
    wait_done();
    issue(8'h80, 8'h01, 1'b0, 1'b1, '{s: 8'h7F, c: 1'b1, o: 1'b1});
    wait_done();

    // Backpressure in DONE with input noise
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 1'b0, '{s: 8'h46, c: 1'b0, o: 1'b0});
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = 8'(i * 37); b = ~8'(i);
      step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h46);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Operands must be latched at the accept edge only
    issue(8'h01, 8'h01, 1'b0, 1'b0, '{s: 8'h02, c: 1'b0, o: 1'b0});
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    wait_done();

    // Reset in the middle of RUN aborts the operation
    issue(8'h55, 8'h11, 1'b0, 1'b0, '{s: 8'h66, c: 1'b0, o: 1'b0});
    step(); step(); step();
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    issue(8'h7F, 8'h01, 1'b0, 1'b0, '{s: 8'h80, c: 1'b0, o: 1'b1});
    wait_done();

    n = 0;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (q.size() != 0) check("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
